// File: rtl/div8_pkg.sv
// div8_pkg: shared operand width, bit-counter width and FSM state type for div8_iter.
package div8_pkg;
  localparam int DIV8_W = 8;
  localparam int CNT_W = $clog2(DIV8_W);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/div8_step.sv
// div8_step: one combinational restoring-division step (shift in a dividend bit, trial subtract).
module div8_step
  import div8_pkg::*;
(
  input  logic [DIV8_W-1:0] rem,
  input  logic              a_bit,
  input  logic [DIV8_W-1:0] div,
  output logic [DIV8_W-1:0] rem_nxt,
  output logic              q_bit
);
  logic [DIV8_W:0] t;
  logic [DIV8_W:0] diff;
  // rem[7] is always clear before a step, so this equals {0, rem[6:0], a_bit}
  assign t       = {rem, a_bit};
  assign diff    = t - {1'b0, div};
  assign q_bit   = ~diff[DIV8_W];
  assign rem_nxt = q_bit ? diff[DIV8_W-1:0] : t[DIV8_W-1:0];
endmodule

// File: rtl/div8_iter.sv
// div8_iter: iterative 8-bit unsigned restoring divider, one quotient bit per cycle, MSB first.
// Define DIV8_ITER_REM_EN to expose the remainder on port R.
module div8_iter
  import div8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIV8_W-1:0] A,
  input  logic [DIV8_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIV8_W-1:0] Q,
`ifdef DIV8_ITER_REM_EN
  output logic [DIV8_W-1:0] R,
`endif
  output logic              div0
);
  state_t            state, state_nxt;
  logic [DIV8_W-1:0] a, b, rem, rem_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              q_bit, accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (state == BUSY) && (cnt == '0);

  div8_step u_step (
    .rem    (rem),
    .a_bit  (a[cnt]),
    .div    (b),
    .rem_nxt(rem_nxt),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb
    state_nxt = accept            ? BUSY :
                last              ? DONE :
                (state == BUSY)   ? BUSY :
                (state == DONE && !out_ready) ? DONE : IDLE;

  always_comb begin
    in_ready  = (state == IDLE) || (state == DONE && out_ready);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a    <= '0;
      b    <= '0;
      rem  <= '0;
      cnt  <= '0;
      Q    <= '0;
      div0 <= 1'b0;
`ifdef DIV8_ITER_REM_EN
      R    <= '0;
`endif
    end else if (accept) begin
      a   <= A;
      b   <= B;
      rem <= '0;
      cnt <= '1;
    end else if (state == BUSY) begin
      rem    <= rem_nxt;
      Q[cnt] <= q_bit;
      cnt    <= cnt - 1'b1;
      if (last) begin
        div0 <= (b == '0);
`ifdef DIV8_ITER_REM_EN
        R    <= rem_nxt;
`endif
      end
    end
endmodule
